// File: rtl/fixed_pkg.sv
// Shared Q6.10 fixed-point constants, divider state encoding and sign helpers.
package fixed_pkg;
  localparam int WIDTH = 16;
  localparam int FRAC  = 10;
  localparam int ITER  = WIDTH + FRAC;
  localparam int CNT_W = $clog2(ITER);

  localparam logic [WIDTH-1:0] SAT_POS = 16'h7FFF;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Two's-complement negate; used to re-apply the sign to a magnitude.
  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude as unsigned; the most negative code maps to 16'h8000.
  function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? f_neg(x) : x;
  endfunction
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step
  import fixed_pkg::*;
(
  input  logic [WIDTH:0]   rem,
  input  logic             msb,
  input  logic [WIDTH-1:0] den,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < den keeps rem[WIDTH] clear; if ever set, the true shifted value
  // exceeds any divisor, so the bit forces a 1 and the wrapped diff is exact.
  always_comb begin
    shifted  = {rem[WIDTH-1:0], msb};
    diff     = shifted - {1'b0, den};
    q_bit    = rem[WIDTH] | (shifted >= {1'b0, den});
    rem_next = q_bit ? diff : shifted;
  end
endmodule

// File: rtl/fixed_divider.sv
// Sequential signed Q6.10 divider: one restoring quotient bit per clock, saturating result.
module fixed_divider
  import fixed_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_num,
  input  logic [WIDTH-1:0] i_den,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sat
);
  state_t           state;
  logic [ITER-1:0]  dividend;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] den_mag;
  logic [ITER-2:0]  quo;
  logic [CNT_W-1:0] cnt;
  logic             sign;

  logic [WIDTH:0]   rem_next;
  logic             q_bit;
  logic [ITER-1:0]  q_next;
  logic [WIDTH-1:0] num_abs, den_abs;
  logic [WIDTH-1:0] mag, res;
  logic             sat_now;

  div_step u_step (
    .rem      (rem),
    .msb      (dividend[ITER-1]),
    .den      (den_mag),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Result path only matters on the final CALC step, when q_next is the full quotient.
  always_comb begin
    num_abs = f_abs(i_num);
    den_abs = f_abs(i_den);
    q_next  = {quo, q_bit};
    sat_now = |q_next[ITER-1:WIDTH-1];
    mag     = sat_now ? SAT_POS : q_next[WIDTH-1:0];
    res     = sign ? f_neg(mag) : mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dividend <= '0;
      rem      <= '0;
      den_mag  <= '0;
      quo      <= '0;
      cnt      <= '0;
      sign     <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_data   <= '0;
      o_sat    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          o_done <= 1'b0;
          if (i_start) begin
            den_mag  <= den_abs;
            dividend <= {num_abs, {FRAC{1'b0}}};
            rem      <= '0;
            quo      <= '0;
            cnt      <= CNT_W'(ITER - 1);
            if (den_abs == '0) begin
              // Divide-by-zero: saturate immediately, sign from the dividend alone.
              sign   <= i_num[WIDTH-1];
              state  <= DONE;
              o_done <= 1'b1;
              o_data <= i_num[WIDTH-1] ? f_neg(SAT_POS) : SAT_POS;
              o_sat  <= 1'b1;
            end else begin
              sign   <= i_num[WIDTH-1] ^ i_den[WIDTH-1];
              state  <= CALC;
              o_busy <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          dividend <= {dividend[ITER-2:0], 1'b0};
          rem      <= rem_next;
          quo      <= q_next[ITER-2:0];
          cnt      <= cnt - 1'b1;
          if (cnt == '0) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            o_data <= res;
            o_sat  <= sat_now;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_divider.sv
// Self-checking bench: fixed vectors, random ops vs an arithmetic model, and corner sequences.
module tb_fixed_divider;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [15:0] i_num, i_den;
  logic        o_busy, o_done, o_sat;
  logic [15:0] o_data;

  int checks = 0;
  int errors = 0;

  fixed_divider dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start),
    .i_num   (i_num),
    .i_den   (i_den),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_data  (o_data),
    .o_sat   (o_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] num;
    logic [15:0] den;
    logic [15:0] data;
    logic        sat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Quotient from plain integer arithmetic on the real-valued operands.
  task automatic model(input logic [15:0] n, input logic [15:0] d,
                       output logic [15:0] data, output logic sat, output int lat);
    longint an, ad, q;
    logic   neg;
    int     mag;
    an = n[15] ? 65536 - longint'(n) : longint'(n);
    ad = d[15] ? 65536 - longint'(d) : longint'(d);
    if (ad == 0) begin
      sat = 1'b1; mag = 32767; neg = n[15]; lat = 1;
    end else begin
      q   = (an * 1024) / ad;
      sat = (q > 32767);
      mag = sat ? 32767 : int'(q);
      neg = n[15] ^ d[15];
      lat = 27;
    end
    data = neg ? 16'(-mag) : 16'(mag);
  endtask

  // Called at a negedge; waits for o_done. lat counts negedges after the start edge.
  task automatic run_op(input logic [15:0] n, input logic [15:0] d, input int inj,
                        output logic [15:0] data, output logic sat,
                        output int lat, output int busy_cnt);
    logic [15:0] held;
    bit          stable;
    held = o_data; stable = 1'b1;
    i_num = n; i_den = d; i_start = 1'b1;
    lat = 0; busy_cnt = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        i_start = 1'b0; i_num = 16'($urandom); i_den = 16'($urandom);
      end
      if (lat == inj) begin
        i_start = 1'b1; i_num = 16'h1234; i_den = 16'h0100;
      end else if (lat == inj + 1) begin
        i_start = 1'b0;
      end
      if (o_done) break;
      if (o_busy) busy_cnt++;
      if (o_data !== held) stable = 1'b0;
    end
    chk("done_seen", o_done, 1);
    chk("held_in_calc", stable, 1);
    data = o_data; sat = o_sat;
  endtask

  task automatic op_check(input string name, input logic [15:0] n, input logic [15:0] d,
                          input logic [15:0] edata, input logic esat, input int inj);
    logic [15:0] data; logic sat; int lat, bc, elat; logic [15:0] md; logic ms;
    model(n, d, md, ms, elat);
    run_op(n, d, inj, data, sat, lat, bc);
    chk({name, "_data"}, data, edata);
    chk({name, "_sat"}, sat, esat);
    chk({name, "_lat"}, lat, elat);
    chk({name, "_busy"}, bc, (elat == 1) ? 0 : 26);
  endtask

  vec_t vecs[11];

  initial begin
    logic [15:0] n, d, ed, data;
    logic        es, sat, seen;
    int          el, lat, bc;

    vecs[0]  = '{16'h0800, 16'h0200, 16'h1000, 1'b0};
    vecs[1]  = '{16'h0400, 16'h0C00, 16'h0155, 1'b0};
    vecs[2]  = '{16'hF400, 16'h0800, 16'hFA00, 1'b0};
    vecs[3]  = '{16'h7FFF, 16'h0001, 16'h7FFF, 1'b1};
    vecs[4]  = '{16'h8000, 16'h0001, 16'h8001, 1'b1};
    vecs[5]  = '{16'h0400, 16'h0000, 16'h7FFF, 1'b1};
    vecs[6]  = '{16'hFC00, 16'h0000, 16'h8001, 1'b1};
    vecs[7]  = '{16'h8000, 16'h8000, 16'h0400, 1'b0};
    vecs[8]  = '{16'hFFFF, 16'h0400, 16'hFFFF, 1'b0};
    vecs[9]  = '{16'hFFFF, 16'h7FFF, 16'h0000, 1'b0};
    vecs[10] = '{16'h0000, 16'hFC00, 16'h0000, 1'b0};

    rst_n = 1'b0; i_start = 1'b0; i_num = '0; i_den = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_data", o_data, 0);
    chk("rst_sat",  o_sat,  0);
    rst_n = 1'b1;
    @(negedge clk);

    // Consecutive calls start from the DONE cycle, so these also run back-to-back.
    foreach (vecs[i])
      op_check($sformatf("vec%0d", i), vecs[i].num, vecs[i].den, vecs[i].data, vecs[i].sat, -1);

    // Start pulsed mid-CALC must be ignored.
    op_check("midcalc", 16'h0400, 16'h0C00, 16'h0155, 1'b0, 6);
    op_check("after_mid", 16'hF400, 16'h0800, 16'hFA00, 1'b0, -1);

    for (int k = 0; k < 150; k++) begin
      n = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       d = 16'h0000;
        1:       d = 16'($urandom_range(1, 3));
        2:       d = 16'h8000;
        default: d = 16'($urandom);
      endcase
      model(n, d, ed, es, el);
      op_check($sformatf("rnd%0d", k), n, d, ed, es, -1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Reset mid-CALC aborts with no result.
    op_check("pre_rst", 16'h0400, 16'h0C00, 16'h0155, 1'b0, -1);
    i_num = 16'h0800; i_den = 16'h0300; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (10) @(negedge clk);
    chk("calc_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", o_busy, 0);
    chk("arst_done", o_done, 0);
    chk("arst_data", o_data, 0);
    chk("arst_sat",  o_sat,  0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (o_done || o_busy) seen = 1'b1;
    end
    chk("no_done_after_rst", seen, 0);
    op_check("post_rst", 16'h0400, 16'h0400, 16'h0400, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
